// File: rtl/router_fsm.sv
// Router control FSM: sequences header decode, payload and parity loading
// into the selected destination FIFO, with full-FIFO stalls and timeout aborts.
// Optional feature: define ROUTER_FSM_ERR_CNT_EN to add a saturating parity
// error counter (input err, output err_count).
module router_fsm (
  input  logic       clock,
  input  logic       reset,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
`ifdef ROUTER_FSM_ERR_CNT_EN
  input  logic       err,
  output logic [7:0] err_count,
`endif
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } stateT;

  stateT      r_state;
  stateT      w_nextState;
  logic [1:0] r_dest;
  logic [3:0] w_emptyVec;
  logic [3:0] w_softVec;
  logic       w_addrOk;

  // Index 3 of each vector is padding so an invalid address reads as 0.
  assign w_emptyVec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign w_softVec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign w_addrOk   = pkt_valid && (data_in != 2'd3);

  // Next-state selection; a soft reset of the latched destination aborts any packet.
  always_comb begin
    w_nextState = r_state;
    if (r_state != DECODE_ADDRESS && w_softVec[r_dest]) begin
      w_nextState = DECODE_ADDRESS;
    end else begin
      case (r_state)
        DECODE_ADDRESS:
          if (w_addrOk)
            w_nextState = w_emptyVec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        WAIT_TILL_EMPTY:
          if (w_emptyVec[r_dest]) w_nextState = LOAD_FIRST_DATA;
        LOAD_FIRST_DATA:
          w_nextState = LOAD_DATA;
        LOAD_DATA:
          if (fifo_full)       w_nextState = FIFO_FULL_STATE;
          else if (!pkt_valid) w_nextState = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!fifo_full) w_nextState = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (parity_done)        w_nextState = DECODE_ADDRESS;
          else if (low_pkt_valid) w_nextState = LOAD_PARITY;
          else                    w_nextState = LOAD_DATA;
        LOAD_PARITY:
          w_nextState = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          w_nextState = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        default:
          w_nextState = DECODE_ADDRESS;
      endcase
    end
  end

  // State, destination latch and registered Moore decodes of the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= DECODE_ADDRESS;
      r_dest        <= 2'd0;
      detect_add    <= 1'b1;
      lfd_state     <= 1'b0;
      ld_state      <= 1'b0;
      laf_state     <= 1'b0;
      full_state    <= 1'b0;
      rst_int_reg   <= 1'b0;
      write_enb_reg <= 1'b0;
      busy          <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == DECODE_ADDRESS && w_addrOk)
        r_dest <= data_in;
      detect_add    <= (w_nextState == DECODE_ADDRESS);
      lfd_state     <= (w_nextState == LOAD_FIRST_DATA);
      ld_state      <= (w_nextState == LOAD_DATA);
      laf_state     <= (w_nextState == LOAD_AFTER_FULL);
      full_state    <= (w_nextState == FIFO_FULL_STATE);
      rst_int_reg   <= (w_nextState == CHECK_PARITY_ERROR);
      write_enb_reg <= (w_nextState == LOAD_DATA) || (w_nextState == LOAD_PARITY) ||
                       (w_nextState == LOAD_AFTER_FULL);
      busy          <= !((w_nextState == DECODE_ADDRESS) || (w_nextState == LOAD_DATA));
    end
  end

`ifdef ROUTER_FSM_ERR_CNT_EN
  // Count parity errors seen while checking parity, holding at the maximum.
  always_ff @(posedge clock) begin
    if (reset)
      err_count <= 8'd0;
    else if (r_state == CHECK_PARITY_ERROR && err && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port pkt_valid, input, 1 bit: source packet valid; deassertion marks the parity byte.
REQ-004 SHALL have port data_in, input, 2 bits: header destination address; 0/1/2 valid, 3 invalid.
REQ-005 SHALL have port fifo_full, input, 1 bit: selected destination FIFO full, from synchronizer.
REQ-006 SHALL have ports fifo_empty_0/1/2, input, 1 bit each: per-FIFO empty flags.
REQ-007 SHALL have ports soft_reset_0/1/2, input, 1 bit each: per-FIFO timeout soft reset, from synchronizer.
REQ-008 SHALL have ports parity_done and low_pkt_valid, input, 1 bit each: register-block status.
REQ-009 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, output, 1 bit each: state decodes.
REQ-010 SHALL have ports write_enb_reg, rst_int_reg, busy, output, 1 bit each: write request, internal register clear, source stall.

Function
REQ-011 SHALL implement a one-hot or encoded FSM with states DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY.
REQ-012 SHALL latch data_in into a 2-bit dest register when in DECODE_ADDRESS with pkt_valid=1 and data_in!=3.
REQ-013 DECODE_ADDRESS SHALL go to LOAD_FIRST_DATA if pkt_valid, data_in!=3 and fifo_empty_[data_in]=1; to WAIT_TILL_EMPTY if pkt_valid, data_in!=3 and fifo_empty_[data_in]=0; else remain.
REQ-014 data_in=3 with pkt_valid SHALL leave the FSM in DECODE_ADDRESS (packet ignored, no write).
REQ-015 WAIT_TILL_EMPTY SHALL go to LOAD_FIRST_DATA when fifo_empty_[dest]=1, else remain.
REQ-016 LOAD_FIRST_DATA SHALL go to LOAD_DATA unconditionally after one cycle.
REQ-017 LOAD_DATA SHALL go to FIFO_FULL_STATE if fifo_full=1; else LOAD_PARITY if pkt_valid=0; else remain (fifo_full has priority).
REQ-018 FIFO_FULL_STATE SHALL go to LOAD_AFTER_FULL when fifo_full=0, else remain.
REQ-019 LOAD_AFTER_FULL SHALL go to DECODE_ADDRESS if parity_done=1; else LOAD_PARITY if low_pkt_valid=1; else LOAD_DATA.
REQ-020 LOAD_PARITY SHALL go to CHECK_PARITY_ERROR unconditionally.
REQ-021 CHECK_PARITY_ERROR SHALL go to FIFO_FULL_STATE if fifo_full=1, else DECODE_ADDRESS.
REQ-022 soft_reset_[dest]=1 in any state other than DECODE_ADDRESS SHALL force DECODE_ADDRESS next cycle, overriding REQ-013..REQ-021; soft resets of other FIFOs SHALL be ignored.
REQ-023 Outputs SHALL be Moore decodes of the current state: detect_add=DECODE_ADDRESS, lfd_state=LOAD_FIRST_DATA, ld_state=LOAD_DATA, laf_state=LOAD_AFTER_FULL, full_state=FIFO_FULL_STATE, rst_int_reg=CHECK_PARITY_ERROR.
REQ-024 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL, else 0.
REQ-025 busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA, 1 in all other states.

Reset
REQ-026 reset=1 at a rising edge SHALL put the FSM in DECODE_ADDRESS and clear dest to 0, overriding soft resets and all transitions.
REQ-027 During/after reset: detect_add=1, all other outputs 0 (busy=0, write_enb_reg=0); reset mid-packet SHALL abandon the packet with no further writes.

Configuration
REQ-028 Macro ROUTER_FSM_ERR_CNT_EN defined SHALL add input err (1 bit, parity mismatch) and output err_count (8 bits), incremented by 1 on each cycle in CHECK_PARITY_ERROR with err=1, saturating at 255, cleared by reset only.
REQ-029 Macro undefined SHALL omit err and err_count; all other behaviour identical.

Verification
REQ-030 Reset, then pkt_valid=1, data_in=1, fifo_empty_1=1 -> DECODE->LFD->LD; lfd_state high 1 cycle, write_enb_reg=1 from LD.
REQ-031 In LD drop pkt_valid -> LOAD_PARITY then CHECK_PARITY_ERROR (rst_int_reg=1 one cycle, fifo_full=0) -> DECODE_ADDRESS.
REQ-032 data_in=2, fifo_empty_2=0 -> WAIT_TILL_EMPTY with busy=1 until fifo_empty_2=1, then LFD next cycle.
REQ-033 fifo_full=1 in LD -> FIFO_FULL_STATE, write_enb_reg=0; fifo_full=0 with parity_done=0, low_pkt_valid=1 -> LAF -> LOAD_PARITY.
REQ-034 dest=0 in LD: soft_reset_1=1 -> no effect; soft_reset_0=1 -> DECODE_ADDRESS next cycle; data_in=3 -> stays DECODE.
REQ-035 With ROUTER_FSM_ERR_CNT_EN: 300 packets each with err=1 at CHECK_PARITY_ERROR -> err_count=255; reset -> 0.
